// File: rtl/rle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rle_pkg
// Brief    : Shared state encoding and lane helpers for the run-length expander.
// Revision : 1.0  initial release
// ============================================================================
package rle_pkg;

   localparam int MAX_LANES = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      TERM   = 2'd2
   } state_e;

   function automatic int min_run(input int rem, input int lanes);
      if (rem < lanes) return rem;
      return lanes;
   endfunction

   function automatic logic [MAX_LANES-1:0] keep_mask(input int n);
      logic [MAX_LANES-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         if (i == n) break;
         m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rle_beat_builder.sv
`default_nettype none
// ============================================================================
// Module   : rle_beat_builder
// Brief    : Replicates one value into the low n lanes of a beat; other lanes 0.
// Revision : 1.0  initial release
// ============================================================================
module rle_beat_builder
   import rle_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int LANES  = 4,
   parameter int NW     = $clog2(LANES + 1)
) (
   input  logic [DATA_W-1:0]       value_i,
   input  logic [NW-1:0]           n_i,
   output logic [LANES*DATA_W-1:0] out_data_o,
   output logic [LANES-1:0]        out_keep_o
);

   always_comb begin
      out_data_o = '0;
      for (int i = 0; i < LANES; i++) begin
         if (i >= int'(n_i)) continue;
         out_data_o[i*DATA_W +: DATA_W] = value_i;
      end
      out_keep_o = LANES'(keep_mask(int'(n_i)));
   end

endmodule
`default_nettype wire

// File: rtl/rle_stream_expander.sv
`default_nettype none
// ============================================================================
// Module   : rle_stream_expander
// Brief    : Expands (count, value) pairs into lane-wide output beats.
// Revision : 1.0  initial release
// ============================================================================
module rle_stream_expander
   import rle_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CNT_W   = 4,
   parameter int LANES   = 4,
   parameter int MAX_RUN = 15
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CNT_W-1:0]        in_count,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [LANES-1:0]        out_keep,
   output logic                    out_last,
   output logic [15:0]             beats_emitted,
   output logic                    err_run
);

   localparam int               NW        = $clog2(LANES + 1);
   localparam logic [CNT_W-1:0] MAX_RUN_C = CNT_W'(MAX_RUN);

   state_e                    state_q, state_d;
   logic [CNT_W-1:0]          rem_q, rem_d;
   logic [DATA_W-1:0]         val_q, val_d;
   logic                      last_q, last_d;
   logic                      out_valid_q, out_valid_d;
   logic [LANES*DATA_W-1:0]   out_data_q, out_data_d;
   logic [LANES-1:0]          out_keep_q, out_keep_d;
   logic                      out_last_q, out_last_d;
   logic [15:0]               beats_q;
   logic                      err_q, err_d;

   logic                      load_w, over_w, in_ready_w, have_run_w, have_term_w, src_last_w;
   logic [CNT_W-1:0]          clamped_w, src_rem_w, rem_left_w;
   logic [DATA_W-1:0]         src_val_w;
   logic [NW-1:0]             n_w;
   logic [LANES*DATA_W-1:0]   beat_data_w;
   logic [LANES-1:0]          beat_keep_w;

   assign load_w     = !out_valid_q || out_ready;
   assign over_w     = in_count > MAX_RUN_C;
   assign clamped_w  = over_w ? MAX_RUN_C : in_count;
   assign n_w        = NW'(min_run(int'(src_rem_w), LANES));
   assign rem_left_w = src_rem_w - CNT_W'(n_w);

   // In IDLE a freshly accepted pair feeds the beat builder directly, so its
   // first beat lands one cycle after the handshake.
   always_comb begin : p_source
      in_ready_w  = 1'b0;
      have_run_w  = 1'b0;
      have_term_w = 1'b0;
      src_rem_w   = rem_q;
      src_val_w   = val_q;
      src_last_w  = last_q;
      case (state_q)
         IDLE: begin
            in_ready_w = 1'b1;
            if (in_valid) begin
               if (clamped_w != '0) begin
                  have_run_w = 1'b1;
                  src_rem_w  = clamped_w;
                  src_val_w  = in_data;
                  src_last_w = in_last;
               end else begin
                  have_term_w = in_last;
               end
            end
         end
         EXPAND: begin
            have_run_w = 1'b1;
            in_ready_w = load_w && (int'(rem_q) <= LANES);
         end
         TERM:    have_term_w = 1'b1;
         default: ;
      endcase
   end

   rle_beat_builder #(
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .NW     (NW)
   ) u_beat (
      .value_i    (src_val_w),
      .n_i        (n_w),
      .out_data_o (beat_data_w),
      .out_keep_o (beat_keep_w)
   );

   always_comb begin : p_next
      state_d     = state_q;
      rem_d       = rem_q;
      val_d       = val_q;
      last_d      = last_q;
      out_valid_d = out_valid_q && !load_w;
      out_data_d  = out_data_q;
      out_keep_d  = out_keep_q;
      out_last_d  = out_last_q;
      err_d       = err_q || (in_valid && in_ready_w && over_w);
      if (have_term_w) begin
         if (load_w) begin
            out_valid_d = 1'b1;
            out_data_d  = '0;
            out_keep_d  = '0;
            out_last_d  = 1'b1;
            state_d     = IDLE;
         end else begin
            state_d = TERM;
         end
      end else if (have_run_w) begin
         val_d  = src_val_w;
         last_d = src_last_w;
         if (load_w) begin
            out_valid_d = 1'b1;
            out_data_d  = beat_data_w;
            out_keep_d  = beat_keep_w;
            out_last_d  = src_last_w && (rem_left_w == '0);
            rem_d       = rem_left_w;
            state_d     = (rem_left_w != '0) ? EXPAND : IDLE;
         end else begin
            rem_d   = src_rem_w;
            state_d = EXPAND;
         end
      end
      // Next pair taken while the final beat of the current one loads: park it.
      if (state_q == EXPAND && in_valid && in_ready_w) begin
         rem_d  = clamped_w;
         val_d  = in_data;
         last_d = in_last;
         if (clamped_w != '0)  state_d = EXPAND;
         else if (in_last)     state_d = TERM;
         else                  state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rem_q       <= '0;
         val_q       <= '0;
         last_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_keep_q  <= '0;
         out_last_q  <= 1'b0;
         beats_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         if (out_valid_q && out_ready && beats_q != 16'hFFFF) beats_q <= beats_q + 16'd1;
         begin : b_update
            if (flush) begin
               state_q     <= IDLE;
               rem_q       <= '0;
               out_valid_q <= 1'b0;
               disable b_update;
            end
            state_q     <= state_d;
            rem_q       <= rem_d;
            val_q       <= val_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
         end
      end
   end

   assign in_ready      = in_ready_w;
   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_keep      = out_keep_q;
   assign out_last      = out_last_q;
   assign beats_emitted = beats_q;
   assign err_run       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_rle_stream_expander.sv
`default_nettype none
// ============================================================================
// Module   : tb_rle_stream_expander
// Brief    : Scoreboard bench for the run-length expander (MAX_RUN reduced to 10).
// Revision : 1.0  initial release
// ============================================================================
module tb_rle_stream_expander;

   localparam int DATA_W  = 8;
   localparam int CNT_W   = 4;
   localparam int LANES   = 4;
   localparam int MAX_RUN = 10;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid, in_last, out_ready;
   logic [3:0]  in_count;
   logic [7:0]  in_data;
   logic        in_ready, out_valid, out_last, err_run;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic [15:0] beats_emitted;

   beat_t       sb_q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          exp_beats = 0;
   bit          rand_ready = 1'b0;
   bit          stalled = 1'b0;
   logic [31:0] held_data;
   logic [3:0]  held_keep;
   logic        held_last;

   always #5 clk = ~clk;

   rle_stream_expander #(
      .DATA_W  (DATA_W),
      .CNT_W   (CNT_W),
      .LANES   (LANES),
      .MAX_RUN (MAX_RUN)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_count      (in_count),
      .in_data       (in_data),
      .in_last       (in_last),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_keep      (out_keep),
      .out_last      (out_last),
      .beats_emitted (beats_emitted),
      .err_run       (err_run)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic void push_pair(input int c, input logic [7:0] d, input logic l);
      int    r;
      int    n;
      beat_t b;
      r = (c > MAX_RUN) ? MAX_RUN : c;
      if (r == 0) begin
         b.data = '0; b.keep = '0; b.last = 1'b1;
         if (l) sb_q.push_back(b);
         return;
      end
      while (r > 0) begin
         n = (r < LANES) ? r : LANES;
         b.data = '0;
         b.keep = '0;
         for (int i = 0; i < n; i++) begin
            b.data[i*8 +: 8] = d;
            b.keep[i]        = 1'b1;
         end
         r -= n;
         b.last = l && (r == 0);
         sb_q.push_back(b);
      end
   endfunction

   task automatic send_pair(input int c, input logic [7:0] d, input logic l);
      bit done = 1'b0;
      in_valid = 1'b1; in_count = 4'(c); in_data = d; in_last = l;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk); #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
         if (done) break;
      end
      in_valid = 1'b0;
      if (done) push_pair(c, d, l);
      else chk("send_timeout", 32'(done), 32'd1);
   endtask

   task automatic drain();
      bit done = 1'b0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (sb_q.size() == 0 && !out_valid) begin
            done = 1'b1;
            break;
         end
         @(posedge clk); #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
      chk("drain_done", 32'(done), 32'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_count = '0;
      in_data = '0; in_last = 1'b0; out_ready = 1'b1;

      fork
         forever begin
            beat_t e;
            @(negedge clk);
            if (!rst_n) begin
               stalled = 1'b0;
            end else begin
               if (stalled && out_valid) begin
                  chk("stall_data", out_data, held_data);
                  chk("stall_keep", 32'(out_keep), 32'(held_keep));
                  chk("stall_last", 32'(out_last), 32'(held_last));
               end
               if (out_valid && out_ready) begin
                  if (sb_q.size() == 0) begin
                     chk("extra_beat", out_data, 32'hDEAD_BEEF);
                  end else begin
                     e = sb_q.pop_front();
                     chk("beat_data", out_data, e.data);
                     chk("beat_keep", 32'(out_keep), 32'(e.keep));
                     chk("beat_last", 32'(out_last), 32'(e.last));
                     exp_beats++;
                  end
               end
               stalled   = out_valid && !out_ready;
               held_data = out_data;
               held_keep = out_keep;
               held_last = out_last;
            end
         end
      join_none

      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_keep", 32'(out_keep), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_beats", 32'(beats_emitted), 32'd0);
      chk("rst_err", 32'(err_run), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;

      send_pair(6, 8'hA5, 1'b1);
      drain();
      chk("beats_after_6", 32'(beats_emitted), 32'd2);

      send_pair(0, 8'h11, 1'b0);
      send_pair(2, 8'h22, 1'b1);
      drain();

      send_pair(0, 8'h99, 1'b1);
      drain();

      send_pair(9, 8'h3C, 1'b1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      out_ready = 1'b1;
      drain();

      rand_ready = 1'b1;
      for (int k = 0; k < 8; k++)
         send_pair(int'($urandom_range(0, MAX_RUN)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)));
      drain();
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      chk("beats_total", 32'(beats_emitted), 32'(exp_beats));

      chk("err_before", 32'(err_run), 32'd0);
      send_pair(12, 8'h0F, 1'b1);
      drain();
      chk("err_after", 32'(err_run), 32'd1);
      send_pair(3, 8'h5A, 1'b0);
      drain();
      chk("err_sticky", 32'(err_run), 32'd1);

      send_pair(10, 8'h77, 1'b1);
      @(posedge clk); #1;
      out_ready = 1'b0;
      flush     = 1'b1;
      sb_q.delete();
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      chk("flush_err_kept", 32'(err_run), 32'd1);
      chk("flush_beats_kept", 32'(beats_emitted), 32'(exp_beats));
      out_ready = 1'b1;
      send_pair(1, 8'h05, 1'b1);
      drain();

      out_ready = 1'b0;
      send_pair(5, 8'h44, 1'b1);
      @(posedge clk); #1;
      chk("stall_pending", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_out_keep", 32'(out_keep), 32'd0);
      chk("async_beats", 32'(beats_emitted), 32'd0);
      chk("async_err", 32'(err_run), 32'd0);
      sb_q.delete();
      exp_beats = 0;
      @(posedge clk); #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("release_in_ready", 32'(in_ready), 32'd1);
      chk("release_out_valid", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
